// File: rtl/i2c_master_write_if.sv
// Handshake bundle between a requester and the i2c_master_write engine.
//   iStart          : transfer request (one cycle is enough; sampled only when idle)
//   iAddr           : first byte on the wire (address[7:1], R/W[0])
//   iData0, iData1  : second and third bytes
//   oBusy           : transfer in progress
//   oDone           : one-cycle completion pulse (ACKed or NACKed)
//   oNack           : a NACK ended the last transfer; held until the next accepted start
// The requester connects to modport master; the engine uses modport slave.
interface i2c_master_write_if;
    logic       iStart;
    logic [7:0] iAddr;
    logic [7:0] iData0;
    logic [7:0] iData1;
    logic       oBusy;
    logic       oDone;
    logic       oNack;

    modport master (
        output iStart, iAddr, iData0, iData1,
        input  oBusy, oDone, oNack
    );

    modport slave (
        input  iStart, iAddr, iData0, iData1,
        output oBusy, oDone, oNack
    );
endinterface

// File: rtl/i2c_master_write.sv
// Bit-banged I2C master performing a fixed three-byte write:
// START, address byte, data byte 0, data byte 1 (each followed by an ACK slot), STOP.
//   iClock : system clock, all logic on the rising edge
//   iReset : asynchronous, active-low reset
//   bus    : request/status handshake (i2c_master_write_if.slave)
//   oSCL   : I2C clock, push-pull, high when idle
//   ioSDA  : I2C data, open-drain (drives 0 or releases to z)
// CLK_DIV is the number of iClock cycles per SCL quarter period (must be >= 4,
// which also hides the 2-cycle latency of the SDA synchronizer before the ACK sample).
module i2c_master_write #(
    parameter int CLK_DIV = 125
) (
    input  logic                 iClock,
    input  logic                 iReset,
    i2c_master_write_if.slave    bus,
    output logic                 oSCL,
    inout  wire                  ioSDA
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP,
        ST_DONE
    } state_t;

    state_t         state_reg;
    logic [CW-1:0]  q_cnt_reg;      // cycles within the current quarter
    logic [1:0]     qtr_reg;        // quarter within the current slot (q0..q3)
    logic [23:0]    shift_reg;      // outgoing bits, MSB is the bit on the wire
    logic [1:0]     byte_idx_reg;
    logic [2:0]     bit_idx_reg;
    logic           scl_reg;
    logic           sda_low_reg;    // 1 = pull SDA low, 0 = release
    logic           busy_reg;
    logic           done_reg;
    logic           nack_reg;
    logic           tick;
    logic           sda_synced;

    // Two-flop synchronizer on the SDA input; the line idles high.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic q;
            if (gi == 0) begin : g_first
                always_ff @(posedge iClock or negedge iReset) begin
                    if (!iReset) q <= 1'b1;
                    else         q <= ioSDA;
                end
            end else begin : g_rest
                always_ff @(posedge iClock or negedge iReset) begin
                    if (!iReset) q <= 1'b1;
                    else         q <= g_sync[gi-1].q;
                end
            end
        end
    endgenerate

    assign sda_synced = g_sync[1].q;

    // Last cycle of a quarter. The counter only advances in the timed states,
    // so it sits at 0 in IDLE and DONE.
    assign tick = (q_cnt_reg == CW'(CLK_DIV - 1));

    // Line levels are registered and updated on the edge that enters a new
    // quarter, so each quarter shows its own levels from its first cycle.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_reg    <= ST_IDLE;
            q_cnt_reg    <= '0;
            qtr_reg      <= 2'd0;
            shift_reg    <= 24'd0;
            byte_idx_reg <= 2'd0;
            bit_idx_reg  <= 3'd0;
            scl_reg      <= 1'b1;
            sda_low_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            nack_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    q_cnt_reg   <= '0;
                    qtr_reg     <= 2'd0;
                    scl_reg     <= 1'b1;
                    sda_low_reg <= 1'b0;
                    if (bus.iStart) begin
                        shift_reg    <= {bus.iAddr, bus.iData0, bus.iData1};
                        nack_reg     <= 1'b0;
                        byte_idx_reg <= 2'd0;
                        bit_idx_reg  <= 3'd7;
                        busy_reg     <= 1'b1;
                        state_reg    <= ST_START;
                    end
                end

                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end

                default: begin
                    if (!tick) begin
                        q_cnt_reg <= q_cnt_reg + CW'(1);
                    end else begin
                        q_cnt_reg <= '0;
                        qtr_reg   <= qtr_reg + 2'd1;   // wraps to q0 on leaving q3
                        case (state_reg)
                            ST_START: begin
                                case (qtr_reg)
                                    2'd0: sda_low_reg <= 1'b1;   // SDA falls with SCL high
                                    2'd2: scl_reg     <= 1'b0;
                                    2'd3: begin
                                        state_reg   <= ST_BIT;
                                        sda_low_reg <= ~shift_reg[23];
                                    end
                                    default: ;
                                endcase
                            end

                            ST_BIT: begin
                                case (qtr_reg)
                                    2'd1: scl_reg <= 1'b1;
                                    2'd3: begin
                                        scl_reg   <= 1'b0;
                                        shift_reg <= {shift_reg[22:0], 1'b0};
                                        if (bit_idx_reg == 3'd0) begin
                                            state_reg   <= ST_ACK;
                                            sda_low_reg <= 1'b0;
                                        end else begin
                                            bit_idx_reg <= bit_idx_reg - 3'd1;
                                            sda_low_reg <= ~shift_reg[22];
                                        end
                                    end
                                    default: ;
                                endcase
                            end

                            ST_ACK: begin
                                case (qtr_reg)
                                    2'd1: scl_reg <= 1'b1;
                                    2'd3: begin
                                        scl_reg <= 1'b0;
                                        if (sda_synced) begin
                                            nack_reg    <= 1'b1;
                                            state_reg   <= ST_STOP;
                                            sda_low_reg <= 1'b1;
                                        end else if (byte_idx_reg != 2'd2) begin
                                            // The shifter already holds the next byte at its top.
                                            byte_idx_reg <= byte_idx_reg + 2'd1;
                                            bit_idx_reg  <= 3'd7;
                                            state_reg    <= ST_BIT;
                                            sda_low_reg  <= ~shift_reg[23];
                                        end else begin
                                            state_reg   <= ST_STOP;
                                            sda_low_reg <= 1'b1;
                                        end
                                    end
                                    default: ;
                                endcase
                            end

                            ST_STOP: begin
                                case (qtr_reg)
                                    2'd0: scl_reg     <= 1'b1;
                                    2'd1: sda_low_reg <= 1'b0;   // SDA rises with SCL high
                                    2'd3: begin
                                        state_reg <= ST_DONE;
                                        busy_reg  <= 1'b0;
                                        done_reg  <= 1'b1;
                                    end
                                    default: ;
                                endcase
                            end

                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign oSCL      = scl_reg;
    assign ioSDA     = sda_low_reg ? 1'b0 : 1'bz;
    assign bus.oBusy = busy_reg;
    assign bus.oDone = done_reg;
    assign bus.oNack = nack_reg;

endmodule

// File: tb/tb_i2c_master_write.sv
// Directed bench for i2c_master_write (CLK_DIV = 4, 16 cycles per bit slot).
// A small clocked slave model watches SCL/SDA, captures each byte and ACKs
// per a per-byte mask. Expected latencies: 116/44/80 quarters * 4 cycles.
// SCL rising-edge counts include the rise inside STOP (pulses + 1).
module tb_i2c_master_write;

    localparam int CLK_DIV = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl;
    wire  sda_line;

    i2c_master_write_if bus ();

    pullup pu_sda (sda_line);

    i2c_master_write #(.CLK_DIV(CLK_DIV)) dut (
        .iClock (clk),
        .iReset (rst_n),
        .bus    (bus),
        .oSCL   (scl),
        .ioSDA  (sda_line)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ---------------- slave model ----------------
    logic [3:0] ack_mask = 4'hF;        // bit n = ACK byte n
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       s_active = 1'b0;
    logic       s_in_ack = 1'b0;
    logic       s_drive  = 1'b0;
    logic [3:0] s_bit    = 4'd0;
    logic [1:0] s_byte   = 2'd0;
    logic [7:0] s_sr     = 8'd0;
    logic [7:0] rx_bytes [4];
    int         scl_rises = 0;

    assign sda_line = s_drive ? 1'b0 : 1'bz;

    always @(posedge clk) begin
        prev_scl <= scl;
        prev_sda <= sda_line;
        if (!prev_scl && scl) scl_rises <= scl_rises + 1;
        if (prev_scl && scl && prev_sda && !sda_line) begin
            s_active <= 1'b1;
            s_in_ack <= 1'b0;
            s_bit    <= 4'd0;
            s_byte   <= 2'd0;
            s_drive  <= 1'b0;
        end else if (prev_scl && scl && !prev_sda && sda_line) begin
            s_active <= 1'b0;
            s_drive  <= 1'b0;
        end else if (s_active) begin
            if (!prev_scl && scl) begin
                if (s_bit < 4'd8) begin
                    s_sr  <= {s_sr[6:0], sda_line};
                    s_bit <= s_bit + 4'd1;
                end
            end else if (prev_scl && !scl) begin
                if (s_bit == 4'd8 && !s_in_ack) begin
                    rx_bytes[s_byte] <= s_sr;
                    s_drive  <= ack_mask[s_byte];
                    s_in_ack <= 1'b1;
                end else if (s_in_ack) begin
                    s_drive  <= 1'b0;
                    s_in_ack <= 1'b0;
                    s_bit    <= 4'd0;
                    s_byte   <= s_byte + 2'd1;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transfer; indices count negedges from the first cycle oBusy should be high.
    task automatic run_xfer(input logic [7:0] a, input logic [7:0] d0, input logic [7:0] d1,
                            input logic [3:0] mask, input bit poke,
                            output int busy_cnt, output int done_cnt, output int done_at,
                            output int rises, output logic nack_first, output logic nack_end);
        int base;
        ack_mask = mask;
        @(negedge clk);
        bus.iAddr  = a;
        bus.iData0 = d0;
        bus.iData1 = d1;
        bus.iStart = 1'b1;
        base = scl_rises;
        @(negedge clk);
        bus.iStart = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        nack_first = bus.oNack;
        for (int c = 0; c < 3000; c++) begin
            if (bus.oBusy) busy_cnt++;
            if (bus.oDone) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (poke && c == 100) begin
                bus.iAddr  = 8'hFF;
                bus.iData0 = 8'hEE;
                bus.iStart = 1'b1;
            end
            if (poke && c == 101) bus.iStart = 1'b0;
            if (done_at >= 0 && c >= done_at + 20) break;
            @(negedge clk);
        end
        rises    = scl_rises - base;
        nack_end = bus.oNack;
        $display("[TB] xfer addr=%02h d0=%02h d1=%02h mask=%b busy=%0d done_at=%0d dones=%0d nack=%0b rises=%0d",
                 a, d0, d1, mask, busy_cnt, done_at, done_cnt, nack_end, rises);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   busy_cnt, done_cnt, done_at, rises, bad;
        logic nack_first, nack_end;
        bit   found;

        bus.iStart = 1'b0;
        bus.iAddr  = 8'h00;
        bus.iData0 = 8'h00;
        bus.iData1 = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_scl",  32'(scl), 32'd1);
        check("rst_sda",  32'(sda_line), 32'd1);
        check("rst_busy", 32'(bus.oBusy), 32'd0);
        check("rst_done", 32'(bus.oDone), 32'd0);
        check("rst_nack", 32'(bus.oNack), 32'd0);

        // 1000 idle cycles with iStart low
        bad = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (scl !== 1'b1 || sda_line !== 1'b1 || bus.oBusy !== 1'b0 ||
                bus.oDone !== 1'b0 || bus.oNack !== 1'b0) bad++;
        end
        check("idle_1000", 32'(bad), 32'd0);

        // Full ACKed write 42/12/80
        run_xfer(8'h42, 8'h12, 8'h80, 4'hF, 1'b0, busy_cnt, done_cnt, done_at, rises, nack_first, nack_end);
        check("full_busy_cycles", 32'(busy_cnt), 32'd464);
        check("full_done_at",     32'(done_at),  32'd464);
        check("full_done_count",  32'(done_cnt), 32'd1);
        check("full_nack",        32'(nack_end), 32'd0);
        check("full_rx0",         32'(rx_bytes[0]), 32'h42);
        check("full_rx1",         32'(rx_bytes[1]), 32'h12);
        check("full_rx2",         32'(rx_bytes[2]), 32'h80);
        check("full_scl_rises",   32'(rises),    32'd28);

        // Address NACK
        run_xfer(8'h44, 8'h55, 8'hAA, 4'h0, 1'b0, busy_cnt, done_cnt, done_at, rises, nack_first, nack_end);
        check("anack_done_at",   32'(done_at), 32'd176);
        check("anack_nack_held", 32'(nack_end), 32'd1);
        check("anack_rx0",       32'(rx_bytes[0]), 32'h44);
        check("anack_scl_rises", 32'(rises),   32'd10);

        // Data0 NACK; oNack from the previous transfer clears on accept
        run_xfer(8'h42, 8'h3C, 8'hC3, 4'h1, 1'b0, busy_cnt, done_cnt, done_at, rises, nack_first, nack_end);
        check("d0nack_nack_cleared", 32'(nack_first), 32'd0);
        check("d0nack_done_at",      32'(done_at),  32'd320);
        check("d0nack_nack",         32'(nack_end), 32'd1);
        check("d0nack_rx1",          32'(rx_bytes[1]), 32'h3C);
        check("d0nack_scl_rises",    32'(rises),    32'd19);

        // iStart pulse and byte changes mid-transfer are ignored
        run_xfer(8'h42, 8'h12, 8'h80, 4'hF, 1'b1, busy_cnt, done_cnt, done_at, rises, nack_first, nack_end);
        check("poke_done_count", 32'(done_cnt), 32'd1);
        check("poke_busy_cycles", 32'(busy_cnt), 32'd464);
        check("poke_rx0",        32'(rx_bytes[0]), 32'h42);
        check("poke_rx1",        32'(rx_bytes[1]), 32'h12);
        check("poke_nack",       32'(nack_end), 32'd0);

        // iStart held high: one IDLE cycle after DONE, then a new transfer
        ack_mask = 4'hF;
        @(negedge clk);
        bus.iAddr = 8'h42; bus.iData0 = 8'h12; bus.iData1 = 8'h80;
        bus.iStart = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 3000 && !found; c++) begin
            @(negedge clk);
            if (bus.oDone) found = 1'b1;
        end
        check("hold_done1", 32'(found), 32'd1);
        @(negedge clk);
        check("hold_idle_gap", 32'(bus.oBusy), 32'd0);
        @(negedge clk);
        check("hold_restart", 32'(bus.oBusy), 32'd1);
        bus.iStart = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 3000 && !found; c++) begin
            @(negedge clk);
            if (bus.oDone) found = 1'b1;
        end
        check("hold_done2", 32'(found), 32'd1);
        repeat (5) @(negedge clk);

        // Reset during bit 3 of iData0 (slot 14, q1 -> 228 cycles in)
        @(negedge clk);
        bus.iStart = 1'b1;
        @(negedge clk);
        bus.iStart = 1'b0;
        repeat (228) @(negedge clk);
        check("mid_scl_low_before", 32'(scl), 32'd0);
        check("mid_sda_low_before", 32'(sda_line), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_scl",  32'(scl), 32'd1);
        check("mid_rst_sda",  32'(sda_line), 32'd1);
        check("mid_rst_busy", 32'(bus.oBusy), 32'd0);
        check("mid_rst_done", 32'(bus.oDone), 32'd0);
        check("mid_rst_nack", 32'(bus.oNack), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        run_xfer(8'h42, 8'h12, 8'h80, 4'hF, 1'b0, busy_cnt, done_cnt, done_at, rises, nack_first, nack_end);
        check("post_rst_done_at", 32'(done_at), 32'd464);
        check("post_rst_nack",    32'(nack_end), 32'd0);
        check("post_rst_rx2",     32'(rx_bytes[2]), 32'h80);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
